// File: rtl/video_timing_pkg.sv
// Shared 720p raster constants and count types for the video path.
// Downstream blocks import these constants so that they all agree on the raster geometry.
// Contents: H_ACTIVE..V_BP, H_TOTAL, V_TOTAL, count widths, and typedefs for the count buses.
package video_timing_pkg;

  localparam int unsigned H_ACTIVE = 1280;
  localparam int unsigned H_FP     = 110;
  localparam int unsigned H_SYNC   = 40;
  localparam int unsigned H_BP     = 220;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 720;
  localparam int unsigned V_FP     = 5;
  localparam int unsigned V_SYNC   = 5;
  localparam int unsigned V_BP     = 20;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned H_COUNT_W     = 11;
  localparam int unsigned V_COUNT_W     = 10;
  localparam int unsigned FRAME_COUNT_W = 6;

  typedef logic [H_COUNT_W-1:0]     h_count_t;
  typedef logic [V_COUNT_W-1:0]     v_count_t;
  typedef logic [FRAME_COUNT_W-1:0] frame_count_t;

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bus between the timing generator and its consumers.
// Controls: en (pixel advance), resync (restart raster at (0,0)).
// Timing: h_count, v_count, active_draw, hsync, vsync, new_frame, frame_count.
// master = timing generator side, slave = consumer/controller side.
interface video_timing_gen_if;
  import video_timing_pkg::*;

  logic         en;
  logic         resync;
  h_count_t     h_count;
  v_count_t     v_count;
  logic         active_draw;
  logic         hsync;
  logic         vsync;
  logic         new_frame;
  frame_count_t frame_count;

  modport master (
    input  en, resync,
    output h_count, v_count, active_draw, hsync, vsync, new_frame, frame_count
  );

  modport slave (
    output en, resync,
    input  h_count, v_count, active_draw, hsync, vsync, new_frame, frame_count
  );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear.
// Ports: clk, rst_n (async active-low), inc (advance), clr (force to 0, beats inc),
//        count (registered value), count_next (value loaded on the next edge),
//        wrap (count is at its terminal value MAX).
// Resets to MAX so that the first increment after reset lands on 0.
module wrap_counter #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned MAX   = 1649
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;

  // Compare-to-terminal wrap; never relies on natural overflow.
  assign wrap = (count_q == WIDTH'(MAX));

  always_comb begin
    count_next = count_q;
    if (clr) begin
      count_next = '0;
    end else if (inc) begin
      count_next = wrap ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= WIDTH'(MAX);
    end else begin
      count_q <= count_next;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing source (720p by default).
// Ports: clk (pixel clock), rst_n (async active-low reset), vif (video_timing_gen_if.master):
//   en/resync in; h_count, v_count, active_draw, hsync, vsync, new_frame, frame_count out.
// Flags are decoded from the next-state counts and registered, so they line up with the
// registered coordinates on the same cycle.
// Build option: define VIDEO_TIMING_FRAME_COUNT_EN for a live 6-bit frame counter; otherwise
// frame_count is tied to zero and no counter is built.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = video_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = video_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = video_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = video_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = video_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = video_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = video_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = video_timing_pkg::V_BP
) (
  input logic                clk,
  input logic                rst_n,
  video_timing_gen_if.master vif
);
  import video_timing_pkg::*;

  localparam int unsigned HTot     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSyncBeg = H_ACTIVE + H_FP;
  localparam int unsigned HSyncEnd = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VSyncBeg = V_ACTIVE + V_FP;
  localparam int unsigned VSyncEnd = V_ACTIVE + V_FP + V_SYNC;

  h_count_t h_count, h_next;
  v_count_t v_count, v_next;
  logic     h_wrap, v_wrap;
  logic     v_inc;

  logic active_d, active_q;
  logic hsync_d, hsync_q;
  logic vsync_d, vsync_q;
  logic new_frame_d, new_frame_q;

  assign v_inc = h_wrap & vif.en;

  wrap_counter #(
    .WIDTH (H_COUNT_W),
    .MAX   (HTot - 1)
  ) u_h_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (vif.en),
    .clr        (vif.resync),
    .count      (h_count),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  wrap_counter #(
    .WIDTH (V_COUNT_W),
    .MAX   (VTot - 1)
  ) u_v_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (v_inc),
    .clr        (vif.resync),
    .count      (v_count),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  always_comb begin
    active_d    = (h_next < H_COUNT_W'(H_ACTIVE)) && (v_next < V_COUNT_W'(V_ACTIVE));
    hsync_d     = (h_next >= H_COUNT_W'(HSyncBeg)) && (h_next < H_COUNT_W'(HSyncEnd));
    vsync_d     = (v_next >= V_COUNT_W'(VSyncBeg)) && (v_next < V_COUNT_W'(VSyncEnd));
    // resync and the end-of-frame wrap both load (0,0); either is a single frame start.
    new_frame_d = vif.resync | (vif.en & h_wrap & v_wrap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      new_frame_q <= 1'b0;
    end else begin
      active_q    <= active_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      new_frame_q <= new_frame_d;
    end
  end

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  frame_count_t frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (new_frame_d) begin
      frame_q <= frame_q + FRAME_COUNT_W'(1);
    end
  end

  assign vif.frame_count = frame_q;
`else
  assign vif.frame_count = '0;
`endif

  assign vif.h_count     = h_count;
  assign vif.v_count     = v_count;
  assign vif.active_draw = active_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.new_frame   = new_frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 720p instance for line-level behaviour and a
// small-raster instance (16x10) for frame-level behaviour within a short run.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen_if vb ();
  video_timing_gen_if vs ();

  video_timing_gen u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vb)
  );

  // 16 x 10 raster: active 8x6, hsync h=10..12, vsync v=7..8.
  video_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (3),
    .V_ACTIVE (6),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vs)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_fc(input int n);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    return 32'(n % 64);
`else
    return 32'(0 * n);
`endif
  endfunction

  task automatic tick_b(input logic en, input logic rs);
    vb.en = en;
    vb.resync = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_s(input logic en, input logic rs);
    vs.en = en;
    vs.resync = rs;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic        rs;
    int unsigned h;
    int unsigned v;
    logic        nf;
    logic        ad;
    logic        hs;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int nf_b;
    int nf_s;
    int hs_cnt, hs_bad, ad_cnt, ad_bad, h_bad;
    int sv_bad, sa_bad, sh_bad, s_vs_cnt, s_ad_cnt, s_nf_cnt, last_nf, gap_bad;
    int mh, mv;
    logic [31:0] exp_h4[4];
    logic        en4[4];

    tbl[0] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1, 0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1, 0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1, 0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 2, 0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1, 0, 1'b0, 1'b1, 1'b0};

    vb.en = 1'b0; vb.resync = 1'b0;
    vs.en = 1'b0; vs.resync = 1'b0;
    nf_b = 0;
    nf_s = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_h", 32'(vb.h_count), 1649);
    check("rst_v", 32'(vb.v_count), 749);
    check("rst_ad", 32'(vb.active_draw), 0);
    check("rst_hs", 32'(vb.hsync), 0);
    check("rst_vs", 32'(vb.vsync), 0);
    check("rst_nf", 32'(vb.new_frame), 0);
    check("rst_fc", 32'(vb.frame_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Table-driven vectors on the 720p instance
    for (int i = 0; i < 8; i++) begin
      tick_b(tbl[i].en, tbl[i].rs);
      if (tbl[i].nf) nf_b++;
      check($sformatf("tbl%0d_h", i), 32'(vb.h_count), 32'(tbl[i].h));
      check($sformatf("tbl%0d_v", i), 32'(vb.v_count), 32'(tbl[i].v));
      check($sformatf("tbl%0d_nf", i), 32'(vb.new_frame), 32'(tbl[i].nf));
      check($sformatf("tbl%0d_ad", i), 32'(vb.active_draw), 32'(tbl[i].ad));
      check($sformatf("tbl%0d_hs", i), 32'(vb.hsync), 32'(tbl[i].hs));
      check($sformatf("tbl%0d_vs", i), 32'(vb.vsync), 0);
    end
    check("tbl_fc", 32'(vb.frame_count), exp_fc(nf_b));

    // One full line from (0,0)
    tick_b(1'b1, 1'b1);
    nf_b++;
    hs_cnt = 0; hs_bad = 0; ad_cnt = 0; ad_bad = 0; h_bad = 0;
    for (int k = 0; k < 1650; k++) begin
      if (k > 0) tick_b(1'b1, 1'b0);
      if (32'(vb.h_count) != 32'(k) || vb.v_count != '0) h_bad++;
      if (vb.hsync !== (k >= 1390 && k < 1430)) hs_bad++;
      if (vb.hsync === 1'b1) hs_cnt++;
      if (vb.active_draw !== (k < 1280)) ad_bad++;
      if (vb.active_draw === 1'b1) ad_cnt++;
    end
    check("line_h_seq", 32'(h_bad), 0);
    check("line_hs_cnt", 32'(hs_cnt), 40);
    check("line_hs_pos", 32'(hs_bad), 0);
    check("line_ad_cnt", 32'(ad_cnt), 1280);
    check("line_ad_pos", 32'(ad_bad), 0);
    tick_b(1'b1, 1'b0);
    check("hwrap_h", 32'(vb.h_count), 0);
    check("hwrap_v", 32'(vb.v_count), 1);
    check("hwrap_nf", 32'(vb.new_frame), 0);
    check("hwrap_ad", 32'(vb.active_draw), 1);

    // Enable gating at h=500
    repeat (500) tick_b(1'b1, 1'b0);
    check("en_h500", 32'(vb.h_count), 500);
    en4 = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_h4 = '{501, 501, 501, 502};
    for (int i = 0; i < 4; i++) begin
      tick_b(en4[i], 1'b0);
      check($sformatf("en_seq%0d_h", i), 32'(vb.h_count), exp_h4[i]);
      check($sformatf("en_seq%0d_nf", i), 32'(vb.new_frame), 0);
    end

    // resync at (800,1) with en=0
    repeat (298) tick_b(1'b1, 1'b0);
    check("pre_rs_h", 32'(vb.h_count), 800);
    check("pre_rs_v", 32'(vb.v_count), 1);
    tick_b(1'b0, 1'b1);
    nf_b++;
    check("rs_h", 32'(vb.h_count), 0);
    check("rs_v", 32'(vb.v_count), 0);
    check("rs_nf", 32'(vb.new_frame), 1);
    check("rs_ad", 32'(vb.active_draw), 1);
    check("rs_fc", 32'(vb.frame_count), exp_fc(nf_b));
    tick_b(1'b0, 1'b0);
    check("rs_after_nf", 32'(vb.new_frame), 0);
    check("rs_after_h", 32'(vb.h_count), 0);

    // Asynchronous reset mid-line
    repeat (1000) tick_b(1'b1, 1'b0);
    check("mid_h", 32'(vb.h_count), 1000);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_h", 32'(vb.h_count), 1649);
    check("arst_v", 32'(vb.v_count), 749);
    check("arst_ad", 32'(vb.active_draw), 0);
    check("arst_hs", 32'(vb.hsync), 0);
    check("arst_nf", 32'(vb.new_frame), 0);
    check("arst_fc", 32'(vb.frame_count), 0);
    vb.en = 1'b0;

    // Small raster: reset value then two full frames against a coordinate model
    check("s_rst_h", 32'(vs.h_count), 15);
    check("s_rst_v", 32'(vs.v_count), 9);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tick_s(1'b1, 1'b0);
    nf_s++;
    check("s_first_nf", 32'(vs.new_frame), 1);
    check("s_first_ad", 32'(vs.active_draw), 1);
    mh = 0; mv = 0;
    sv_bad = 0; sa_bad = 0; sh_bad = 0; s_vs_cnt = 0; s_ad_cnt = 0; s_nf_cnt = 0;
    last_nf = 0; gap_bad = 0;
    for (int i = 0; i < 320; i++) begin
      if (i > 0) begin
        tick_s(1'b1, 1'b0);
        if (mh == 15) begin
          mh = 0;
          mv = (mv == 9) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
      if (32'(vs.h_count) != 32'(mh) || 32'(vs.v_count) != 32'(mv)) sv_bad++;
      if (vs.active_draw !== (mh < 8 && mv < 6)) sa_bad++;
      if (vs.hsync !== (mh >= 10 && mh < 13)) sh_bad++;
      if (vs.vsync !== (mv >= 7 && mv < 9)) sv_bad++;
      if (vs.vsync === 1'b1) s_vs_cnt++;
      if (vs.active_draw === 1'b1) s_ad_cnt++;
      if (vs.new_frame === 1'b1) begin
        s_nf_cnt++;
        if (i > 0 && i - last_nf != 160) gap_bad++;
        last_nf = i;
      end
    end
    nf_s += s_nf_cnt - 1;
    check("s_coord_vs", 32'(sv_bad), 0);
    check("s_ad_pos", 32'(sa_bad), 0);
    check("s_hs_pos", 32'(sh_bad), 0);
    check("s_vs_cnt", 32'(s_vs_cnt), 64);
    check("s_ad_cnt", 32'(s_ad_cnt), 96);
    check("s_nf_cnt", 32'(s_nf_cnt), 2);
    check("s_nf_gap", 32'(gap_bad), 0);
    check("s_end_h", 32'(vs.h_count), 15);
    check("s_end_v", 32'(vs.v_count), 9);

    // resync coincident with end-of-frame wrap
    tick_s(1'b1, 1'b1);
    nf_s++;
    check("s_co_h", 32'(vs.h_count), 0);
    check("s_co_v", 32'(vs.v_count), 0);
    check("s_co_nf", 32'(vs.new_frame), 1);
    check("s_co_fc", 32'(vs.frame_count), exp_fc(nf_s));
    tick_s(1'b1, 1'b0);
    check("s_co_next_nf", 32'(vs.new_frame), 0);
    check("s_co_next_h", 32'(vs.h_count), 1);
    check("s_co_next_fc", 32'(vs.frame_count), exp_fc(nf_s));

    // Mid-frame reset, then 70 frames via held resync
    tick_s(1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("s_arst_h", 32'(vs.h_count), 15);
    check("s_arst_fc", 32'(vs.frame_count), 0);
    check("s_arst_nf", 32'(vs.new_frame), 0);
    vs.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    repeat (70) tick_s(1'b0, 1'b1);
    check("s_70_fc", 32'(vs.frame_count), exp_fc(70));
    check("s_70_h", 32'(vs.h_count), 0);
    check("s_70_nf", 32'(vs.new_frame), 1);
    tick_s(1'b0, 1'b0);
    check("s_70_hold_nf", 32'(vs.new_frame), 0);
    check("s_70_hold_fc", 32'(vs.frame_count), exp_fc(70));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
